// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// access-size encodings, byte-enable patterns and an access-size decoder.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unused encodings (011, 110, 111) fall through to a full-word access.
  function automatic size_t decode_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: decode_size = SZ_B;
      F3_H, F3_HU: decode_size = SZ_H;
      default:     decode_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated write data for the
// request being issued, plus extraction and extension of the returned load word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misalign
);

  size_t       req_size;
  size_t       ld_size;
  logic [31:0] shifted;
  logic        sign_ext;

  always_comb begin
    req_size = decode_size(funct3);
    be       = BE_WORD;
    wdata    = store_data;
    misalign = 1'b0;
    case (req_size)
      SZ_B: begin
        be    = BE_BYTE << offset;
        wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be       = BE_HALF << offset;
        wdata    = {2{store_data[15:0]}};
        misalign = offset[0];
      end
      default: begin
        be       = BE_WORD;
        wdata    = store_data;
        misalign = |offset;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0; funct3[2] marks the unsigned forms.
  always_comb begin
    ld_size  = decode_size(ld_funct3);
    shifted  = rdata >> {ld_offset, 3'b000};
    sign_ext = ~ld_funct3[2];
    load_ext = rdata;
    case (ld_size)
      SZ_B:    load_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: a four-state bus handshake FSM that issues one aligned
// word-bus access per MEM-stage request and returns extended load data.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            stall,
  output logic            misalign,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  state_t          state;
  state_t          state_next;
  logic            request;
  logic            misalign_raw;
  logic            start;
  logic            rsp_done;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] load_ext;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_offset;

  lsu_align u_align (
    .funct3     (funct3),
    .offset     (address[1:0]),
    .store_data (store_data),
    .ld_funct3  (ld_funct3),
    .ld_offset  (ld_offset),
    .rdata      (bus_rdata),
    .be         (be_next),
    .wdata      (wdata_next),
    .load_ext   (load_ext),
    .misalign   (misalign_raw)
  );

  assign request  = mem_load | mem_store;
  assign start    = (state == IDLE) & request & ~misalign_raw;
  assign rsp_done = ((state == REQ) & bus_gnt & bus_rvalid) |
                    ((state == WAIT) & bus_rvalid);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // DONE always returns to IDLE so the request still visible there is never reissued.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    misalign   = 1'b0;
    bus_req    = 1'b0;
    case (state)
      IDLE: begin
        misalign = request & misalign_raw;
        stall    = start;
        if (start) state_next = REQ;
      end
      REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) state_next = bus_rvalid ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus fields and load-steering info are captured once at launch and held.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ld_funct3 <= '0;
      ld_offset <= '0;
      load_data <= '0;
    end else begin
      if (start) begin
        bus_addr  <= {address[XLEN-1:2], 2'b00};
        bus_we    <= mem_store;
        bus_be    <= be_next;
        bus_wdata <= wdata_next;
        ld_funct3 <= funct3;
        ld_offset <= address[1:0];
      end
      if (rsp_done & ~bus_we) load_data <= load_ext;
    end
  end

endmodule
